// File: rtl/ahb_clac_master_if.sv
// Command/response handshake plus AHB-Lite master bus for the calculator sequencer.
// master = the sequencer's view; slave = the environment (core + calculator slave).
interface ahb_clac_master_if;
   logic        cmd_valid;
   logic        cmd_ready;
   logic [31:0] cmd_mode;
   logic [31:0] cmd_opa;
   logic [31:0] cmd_opb;
   logic        rsp_valid;
   logic        rsp_ready;
   logic [31:0] rsp_data;
   logic        rsp_err;
   logic        hsel;
   logic        hwrite;
   logic        hready;
   logic [2:0]  hsize;
   logic [1:0]  htrans;
   logic [2:0]  hburst;
   logic [31:0] haddr;
   logic [31:0] hwdata;
   logic        hready_resp;
   logic [1:0]  hresp;
   logic [31:0] hrdata;

   modport master (
      input  cmd_valid, cmd_mode, cmd_opa, cmd_opb, rsp_ready,
      input  hready_resp, hresp, hrdata,
      output cmd_ready, rsp_valid, rsp_data, rsp_err,
      output hsel, hwrite, hready, hsize, htrans, hburst, haddr, hwdata
   );

   modport slave (
      output cmd_valid, cmd_mode, cmd_opa, cmd_opb, rsp_ready,
      output hready_resp, hresp, hrdata,
      input  cmd_ready, rsp_valid, rsp_data, rsp_err,
      input  hsel, hwrite, hready, hsize, htrans, hburst, haddr, hwdata
   );
endinterface

// File: rtl/ahb_clac_master.sv
// Sequences one calculator command as five AHB-Lite single transfers (MODE, OPA, OPB, CTRL, RESULT).
// Zero-wait latency: rsp_valid sampled 11+RESULT_GAP edges after accept; response held until rsp_ready.
module ahb_clac_master #(
   parameter logic [31:0] BASE_ADDR  = 32'h0000_0000,
   parameter int          RESULT_GAP = 2,
   parameter int          TIMEOUT    = 16
) (
   input  logic             hclk_i,
   input  logic             hresetn_i,
   ahb_clac_master_if.master bus
);

   localparam int WAIT_RAW = $clog2(TIMEOUT + 1);
   localparam int WAIT_W   = (WAIT_RAW < 4) ? 4 : ((WAIT_RAW > 8) ? 8 : WAIT_RAW);
   localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(TIMEOUT - 1);
   localparam logic [3:0]        GAP_LAST  = 4'((RESULT_GAP > 0) ? (RESULT_GAP - 1) : 0);

   typedef enum logic [2:0] {
      S_IDLE,
      S_ADDR,
      S_DATA,
      S_GAP,
      S_RESP
   } state_t;

   state_t              state_q, state_d;
   logic [2:0]          step_q, step_d;
   logic [31:0]         mode_q, mode_d;
   logic [31:0]         opa_q, opa_d;
   logic [31:0]         opb_q, opb_d;
   logic [WAIT_W-1:0]   wait_q, wait_d;
   logic [3:0]          gap_q, gap_d;
   logic [31:0]         hwdata_q, hwdata_d;
   logic [31:0]         rsp_data_q, rsp_data_d;
   logic                rsp_err_q, rsp_err_d;
   logic [31:0]         addr_off;
   logic [31:0]         wr_val;

   always_ff @(posedge hclk_i or negedge hresetn_i) begin
      if (!hresetn_i) begin
         state_q    <= S_IDLE;
         step_q     <= 3'd0;
         mode_q     <= 32'h0;
         opa_q      <= 32'h0;
         opb_q      <= 32'h0;
         wait_q     <= '0;
         gap_q      <= 4'd0;
         hwdata_q   <= 32'h0;
         rsp_data_q <= 32'h0;
         rsp_err_q  <= 1'b0;
      end else begin
         state_q    <= state_d;
         step_q     <= step_d;
         mode_q     <= mode_d;
         opa_q      <= opa_d;
         opb_q      <= opb_d;
         wait_q     <= wait_d;
         gap_q      <= gap_d;
         hwdata_q   <= hwdata_d;
         rsp_data_q <= rsp_data_d;
         rsp_err_q  <= rsp_err_d;
      end
   end

   // Step order: MODE, OPA, OPB, CTRL (start), RESULT.
   always_comb begin
      addr_off = 32'h0;
      wr_val   = hwdata_q;
      case (step_q)
         3'd0:    begin addr_off = 32'h04; wr_val = mode_q; end
         3'd1:    begin addr_off = 32'h08; wr_val = opa_q;  end
         3'd2:    begin addr_off = 32'h0C; wr_val = opb_q;  end
         3'd3:    begin addr_off = 32'h00; wr_val = 32'h1;  end
         default: begin addr_off = 32'h10; end
      endcase
   end

   always_comb begin
      state_d    = state_q;
      step_d     = step_q;
      mode_d     = mode_q;
      opa_d      = opa_q;
      opb_d      = opb_q;
      wait_d     = wait_q;
      gap_d      = gap_q;
      hwdata_d   = hwdata_q;
      rsp_data_d = rsp_data_q;
      rsp_err_d  = rsp_err_q;
      case (state_q)
         S_IDLE: begin
            if (bus.cmd_valid) begin
               mode_d  = bus.cmd_mode;
               opa_d   = bus.cmd_opa;
               opb_d   = bus.cmd_opb;
               step_d  = 3'd0;
               state_d = S_ADDR;
            end
         end
         S_ADDR: begin
            wait_d  = '0;
            state_d = S_DATA;
            if (step_q != 3'd4) hwdata_d = wr_val;
         end
         S_DATA: begin
            if (bus.hready_resp) begin
               if (bus.hresp != 2'b00) begin
                  rsp_err_d  = 1'b1;
                  rsp_data_d = 32'h0;
                  state_d    = S_RESP;
               end else if (step_q == 3'd4) begin
                  rsp_err_d  = 1'b0;
                  rsp_data_d = bus.hrdata;
                  state_d    = S_RESP;
               end else if (step_q == 3'd3) begin
                  if (RESULT_GAP == 0) begin
                     step_d  = 3'd4;
                     state_d = S_ADDR;
                  end else begin
                     gap_d   = 4'd0;
                     state_d = S_GAP;
                  end
               end else begin
                  step_d  = step_q + 3'd1;
                  state_d = S_ADDR;
               end
            end else if (wait_q == WAIT_LAST) begin
               // Slave stalled for TIMEOUT cycles: abandon the sequence.
               rsp_err_d  = 1'b1;
               rsp_data_d = 32'h0;
               state_d    = S_RESP;
            end else begin
               wait_d = wait_q + 1'b1;
            end
         end
         S_GAP: begin
            if (gap_q == GAP_LAST) begin
               step_d  = 3'd4;
               state_d = S_ADDR;
            end else begin
               gap_d = gap_q + 4'd1;
            end
         end
         S_RESP: begin
            if (bus.rsp_ready) begin
               rsp_data_d = 32'h0;
               rsp_err_d  = 1'b0;
               state_d    = S_IDLE;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   assign bus.cmd_ready = (state_q == S_IDLE);
   assign bus.rsp_valid = (state_q == S_RESP);
   assign bus.rsp_data  = rsp_data_q;
   assign bus.rsp_err   = rsp_err_q;
   assign bus.hsel      = (state_q == S_ADDR);
   assign bus.hwrite    = (state_q == S_ADDR) && (step_q != 3'd4);
   assign bus.hready    = (state_q == S_DATA) ? bus.hready_resp : 1'b1;
   assign bus.hsize     = (state_q == S_ADDR) ? 3'b010 : 3'b000;
   assign bus.htrans    = (state_q == S_ADDR) ? 2'b10 : 2'b00;
   assign bus.hburst    = 3'b000;
   assign bus.haddr     = (state_q == S_ADDR) ? (BASE_ADDR + addr_off) : 32'h0;
   assign bus.hwdata    = hwdata_q;

endmodule

// File: tb/tb_ahb_clac_master.sv
// Directed bench: command driver, scoreboard of expected responses, and a small calculator slave stub.
module tb_ahb_clac_master;
   localparam logic [31:0] BASE = 32'h0000_0000;
   localparam int          RG   = 2;
   localparam int          TO   = 16;

   logic hclk    = 1'b0;
   logic hresetn = 1'b1;
   always #5 hclk = ~hclk;

   ahb_clac_master_if bus();

   ahb_clac_master #(.BASE_ADDR(BASE), .RESULT_GAP(RG), .TIMEOUT(TO)) dut (
      .hclk_i    (hclk),
      .hresetn_i (hresetn),
      .bus       (bus)
   );

   int total = 0;
   int bad   = 0;

   typedef struct {
      logic        err;
      logic [31:0] data;
      int          lat;
   } exp_t;
   exp_t sb[$];

   // Calculator slave stub
   logic [31:0] mode_r = 0, opa_r = 0, opb_r = 0, res_r = 0;
   logic        dp_act = 0, dp_wr = 0;
   logic [31:0] dp_addr = 0;
   int          dp_wait = 0;
   int          ctrl_wr = 0;
   int          nonseq  = 0;
   logic [31:0] aq[$];
   logic [31:0] wq[$];
   logic        stuck = 0, err_en = 0;
   logic [31:0] err_addr = 0, stall_addr = 32'hFFFF_FFFF;
   int          stall_n = 0;

   logic burst_bad = 0, hsize_bad = 0, dbl_bad = 0, hold_bad = 0;
   logic prev_ns = 0, hold_seen = 0;
   logic [31:0] hold_val = 0;

   function automatic logic [31:0] calc(input logic [31:0] m, input logic [31:0] a, input logic [31:0] b);
      case (m[1:0])
         2'd0:    return a & b;
         2'd1:    return a | b;
         2'd2:    return a ^ b;
         default: return a + b;
      endcase
   endfunction

   assign bus.hready_resp = !dp_act || (!stuck && dp_wait == 0);
   assign bus.hresp       = (dp_act && err_en && dp_addr == err_addr) ? 2'b01 : 2'b00;
   assign bus.hrdata      = (dp_act && !dp_wr && dp_addr == BASE + 32'h10) ? res_r : 32'h0;

   always @(posedge hclk or negedge hresetn) begin
      if (!hresetn) begin
         dp_act  <= 1'b0;
         dp_wait <= 0;
      end else begin
         if (dp_act && bus.hready_resp) begin
            if (dp_wr && bus.hresp == 2'b00) begin
               case (dp_addr - BASE)
                  32'h04: mode_r <= bus.hwdata;
                  32'h08: opa_r  <= bus.hwdata;
                  32'h0C: opb_r  <= bus.hwdata;
                  32'h00: begin
                     ctrl_wr <= ctrl_wr + 1;
                     if (bus.hwdata == 32'h1) res_r <= calc(mode_r, opa_r, opb_r);
                  end
                  default: ;
               endcase
            end
            if (dp_wr) wq.push_back(bus.hwdata);
            dp_act <= 1'b0;
         end else if (dp_act && dp_wait > 0) begin
            dp_wait <= dp_wait - 1;
         end
         if (bus.hsel && bus.htrans == 2'b10 && bus.hready) begin
            dp_act  <= 1'b1;
            dp_addr <= bus.haddr;
            dp_wr   <= bus.hwrite;
            dp_wait <= (bus.haddr == stall_addr) ? stall_n : 0;
            aq.push_back(bus.haddr);
            nonseq  <= nonseq + 1;
            if (bus.hsize != 3'b010) hsize_bad <= 1'b1;
         end
      end
   end

   // Protocol monitors, sampled mid-cycle.
   always @(negedge hclk) begin
      if (bus.hburst != 3'b000) burst_bad <= 1'b1;
      if (bus.htrans == 2'b10 && prev_ns) dbl_bad <= 1'b1;
      if (bus.hsel && bus.htrans != 2'b10) dbl_bad <= 1'b1;
      prev_ns <= (bus.htrans == 2'b10);
      if (dp_act && dp_wr) begin
         if (!hold_seen) begin
            hold_seen <= 1'b1;
            hold_val  <= bus.hwdata;
         end else if (bus.hwdata != hold_val) begin
            hold_bad <= 1'b1;
         end
      end else begin
         hold_seen <= 1'b0;
      end
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      total++;
      assert (obs === expv) else begin
         bad++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
      end
   endtask

   task automatic drive_cmd(input logic [31:0] m, input logic [31:0] a, input logic [31:0] b, input string tag);
      int k = 0;
      @(negedge hclk);
      bus.cmd_valid = 1'b1;
      bus.cmd_mode  = m;
      bus.cmd_opa   = a;
      bus.cmd_opb   = b;
      while (!bus.cmd_ready && k < 50) begin
         @(negedge hclk);
         k++;
      end
      if (k >= 50) chk({tag, "_cmd_ready_wait"}, 32'd0, 32'd1);
      @(posedge hclk);
      #1;
      bus.cmd_valid = 1'b0;
      bus.cmd_mode  = ~m;
      bus.cmd_opa   = ~a;
      bus.cmd_opb   = ~b;
   endtask

   task automatic run_cmd(input logic [31:0] m, input logic [31:0] a, input logic [31:0] b, input int bp,
                          input logic exp_err, input logic [31:0] exp_data, input int exp_lat, input string tag);
      int          lat = 0;
      logic        got = 1'b0;
      logic        stable = 1'b1;
      logic [31:0] d0;
      logic        e0;
      exp_t        e;
      sb.push_back('{exp_err, exp_data, exp_lat});
      drive_cmd(m, a, b, tag);
      for (int i = 0; i < 200 && !got; i++) begin
         @(negedge hclk);
         lat++;
         if (bus.rsp_valid) got = 1'b1;
      end
      if (!got) begin
         chk({tag, "_rsp_wait"}, 32'd0, 32'd1);
         void'(sb.pop_front());
         return;
      end
      d0 = bus.rsp_data;
      e0 = bus.rsp_err;
      repeat (bp) begin
         @(negedge hclk);
         if (!bus.rsp_valid || bus.rsp_data !== d0 || bus.rsp_err !== e0 || bus.cmd_ready) stable = 1'b0;
      end
      if (bp > 0) chk({tag, "_backpressure_stable"}, {31'd0, stable}, 32'd1);
      e = sb.pop_front();
      chk({tag, "_data"},    bus.rsp_data, e.data);
      chk({tag, "_err"},     {31'd0, bus.rsp_err}, {31'd0, e.err});
      chk({tag, "_latency"}, lat, e.lat);
      bus.rsp_ready = 1'b1;
      @(posedge hclk);
      #1;
      bus.rsp_ready = 1'b0;
      @(negedge hclk);
      chk({tag, "_rsp_drop"}, {31'd0, bus.rsp_valid}, 32'd0);
   endtask

   initial begin
      int          ns0, ab, wb, cw0, k;
      logic [31:0] ea[5];
      logic [31:0] ew[4];
      logic [31:0] m, a, b;

      bus.cmd_valid = 1'b0;
      bus.cmd_mode  = 32'h0;
      bus.cmd_opa   = 32'h0;
      bus.cmd_opb   = 32'h0;
      bus.rsp_ready = 1'b0;

      #2 hresetn = 1'b0;
      #1;
      chk("rst_cmd_ready", {31'd0, bus.cmd_ready}, 32'd1);
      chk("rst_hready",    {31'd0, bus.hready},    32'd1);
      chk("rst_rsp_valid", {31'd0, bus.rsp_valid}, 32'd0);
      chk("rst_hsel",      {31'd0, bus.hsel},      32'd0);
      chk("rst_htrans",    {30'd0, bus.htrans},    32'd0);
      chk("rst_haddr",     bus.haddr,              32'd0);
      chk("rst_hwdata",    bus.hwdata,             32'd0);
      repeat (3) @(negedge hclk);
      hresetn = 1'b1;

      // AND case with full bus trace.
      ns0 = nonseq; ab = aq.size(); wb = wq.size();
      run_cmd(32'h0, 32'h3254, 32'h0, 0, 1'b0, 32'h0, 11 + RG, "and");
      ea = '{32'h04, 32'h08, 32'h0C, 32'h00, 32'h10};
      ew = '{32'h0, 32'h3254, 32'h0, 32'h1};
      chk("and_nonseq_count", nonseq - ns0, 32'd5);
      for (int i = 0; i < 5; i++) chk($sformatf("and_haddr%0d", i), aq[ab + i], BASE + ea[i]);
      for (int i = 0; i < 4; i++) chk($sformatf("and_hwdata%0d", i), wq[wb + i], ew[i]);

      run_cmd(32'h1, 32'hA5A5_0000, 32'h0000_5A5A, 0, 1'b0, 32'hA5A5_5A5A, 11 + RG, "or");
      for (int i = 0; i < 3; i++) begin
         m = $urandom_range(0, 3);
         a = $urandom;
         b = $urandom;
         run_cmd(m, a, b, 0, 1'b0, calc(m, a, b), 11 + RG, $sformatf("rand%0d", i));
      end

      // Three wait states on the OPB write.
      stall_addr = BASE + 32'h0C; stall_n = 3;
      ns0 = nonseq;
      run_cmd(32'h3, 32'h1000, 32'h0234, 0, 1'b0, 32'h1234, 14 + RG, "wait");
      chk("wait_nonseq_count", nonseq - ns0, 32'd5);
      stall_addr = 32'hFFFF_FFFF;

      // ERROR response on the OPA write.
      err_en = 1'b1; err_addr = BASE + 32'h08;
      ns0 = nonseq; cw0 = ctrl_wr;
      run_cmd(32'h0, 32'hFFFF, 32'hFFFF, 0, 1'b1, 32'h0, 5, "err");
      chk("err_nonseq_count", nonseq - ns0, 32'd2);
      chk("err_no_ctrl", ctrl_wr, cw0);
      err_en = 1'b0;

      // Timeout on a stuck slave, with response back-pressure.
      stuck = 1'b1;
      run_cmd(32'h0, 32'h1, 32'h1, 5, 1'b1, 32'h0, TO + 2, "timeout");
      stuck = 1'b0;
      repeat (2) @(negedge hclk);

      // Async reset during the OPB data phase.
      stall_addr = BASE + 32'h0C; stall_n = 3;
      drive_cmd(32'h0, 32'h5555, 32'hCAFE_F00D, "rst");
      k = 0;
      while (!(dp_act && dp_addr == BASE + 32'h0C) && k < 40) begin
         @(negedge hclk);
         k++;
      end
      chk("rst_reach_opb", {31'd0, dp_act}, 32'd1);
      #2 hresetn = 1'b0;
      #1;
      chk("arst_cmd_ready", {31'd0, bus.cmd_ready}, 32'd1);
      chk("arst_hready",    {31'd0, bus.hready},    32'd1);
      chk("arst_hwdata",    bus.hwdata,             32'd0);
      chk("arst_htrans",    {30'd0, bus.htrans},    32'd0);
      repeat (2) @(negedge hclk);
      hresetn = 1'b1;
      stall_addr = 32'hFFFF_FFFF;
      repeat (3) @(negedge hclk);
      chk("arst_no_rsp", {31'd0, bus.rsp_valid}, 32'd0);
      run_cmd(32'h2, 32'hF0F0_F0F0, 32'h0FF0_0FF0, 0, 1'b0, 32'hFF00_FF00, 11 + RG, "post_rst");

      chk("hburst_always_single", {31'd0, burst_bad}, 32'd0);
      chk("hsize_word",           {31'd0, hsize_bad}, 32'd0);
      chk("nonseq_single_cycle",  {31'd0, dbl_bad},   32'd0);
      chk("hwdata_held",          {31'd0, hold_bad},  32'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
